// File: rtl/stack_seq.sv
// 8085 PUSH/POP stack sequencer: owns SP and splits each word into two byte accesses.
// Zero-wait latency start->done is 3 cycles; each mem_ack wait cycle adds one.
module stack_seq #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stk_op,
  input  logic [2*DATASIZE-1:0] iData,
  output logic [2*DATASIZE-1:0] oData,
  input  logic                  sp_load,
  input  logic [ADDRSIZE-1:0]   iSP,
  output logic [ADDRSIZE-1:0]   oSP,
  output logic                  busy,
  output logic                  done,
  output logic [ADDRSIZE-1:0]   mem_addr,
  output logic [DATASIZE-1:0]   mem_wdata,
  input  logic [DATASIZE-1:0]   mem_rdata,
  output logic                  mem_wr,
  output logic                  mem_rd,
  input  logic                  mem_ack
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PUSH_HI = 3'd1;
  localparam logic [2:0] S_PUSH_LO = 3'd2;
  localparam logic [2:0] S_POP_LO  = 3'd3;
  localparam logic [2:0] S_POP_HI  = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;

  logic [2:0]          r_state;
  logic [DATASIZE-1:0] r_wlo;
  logic [DATASIZE-1:0] r_rlo;

  logic [ADDRSIZE-1:0] w_sp_m1;
  logic [ADDRSIZE-1:0] w_sp_m2;
  logic [ADDRSIZE-1:0] w_sp_p1;
  logic [ADDRSIZE-1:0] w_sp_p2;

  // SP only moves at the final ack, so these offsets stay valid for the whole op.
  assign w_sp_m1 = oSP - ADDRSIZE'(1);
  assign w_sp_m2 = oSP - ADDRSIZE'(2);
  assign w_sp_p1 = oSP + ADDRSIZE'(1);
  assign w_sp_p2 = oSP + ADDRSIZE'(2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wlo     <= '0;
      r_rlo     <= '0;
      oSP       <= '0;
      oData     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wr    <= 1'b0;
      mem_rd    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (sp_load) begin
            oSP <= iSP;
          end else if (start) begin
            busy  <= 1'b1;
            r_wlo <= iData[DATASIZE-1:0];
            if (stk_op) begin
              r_state  <= S_POP_LO;
              mem_rd   <= 1'b1;
              mem_addr <= oSP;
            end else begin
              r_state   <= S_PUSH_HI;
              mem_wr    <= 1'b1;
              mem_addr  <= w_sp_m1;
              mem_wdata <= iData[2*DATASIZE-1:DATASIZE];
            end
          end
        end
        S_PUSH_HI: begin
          if (mem_ack) begin
            r_state   <= S_PUSH_LO;
            mem_addr  <= w_sp_m2;
            mem_wdata <= r_wlo;
          end
        end
        S_PUSH_LO: begin
          if (mem_ack) begin
            r_state <= S_FIN;
            mem_wr  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            oSP     <= w_sp_m2;
          end
        end
        S_POP_LO: begin
          if (mem_ack) begin
            r_state  <= S_POP_HI;
            r_rlo    <= mem_rdata;
            mem_addr <= w_sp_p1;
          end
        end
        S_POP_HI: begin
          if (mem_ack) begin
            r_state <= S_FIN;
            mem_rd  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            oData   <= {mem_rdata, r_rlo};
            oSP     <= w_sp_p2;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          mem_wr  <= 1'b0;
          mem_rd  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq with a byte-memory responder that supports programmable wait states.
module tb_stack_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stk_op;
  logic [15:0] iData;
  logic [15:0] oData;
  logic        sp_load;
  logic [15:0] iSP;
  logic [15:0] oSP;
  logic        busy;
  logic        done;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_wr;
  logic        mem_rd;
  logic        mem_ack;
  logic        resp_ack;
  logic        stray_ack;

  int errors = 0;
  int checks = 0;

  stack_seq #(.DATASIZE(8), .ADDRSIZE(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stk_op(stk_op), .iData(iData), .oData(oData),
    .sp_load(sp_load), .iSP(iSP), .oSP(oSP), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;
  assign mem_ack = resp_ack | stray_ack;

  // Memory responder: acks after wait_n stall cycles and logs every completed access.
  logic [7:0]  mem [0:65535];
  int          wait_n = 0;
  int          wcnt = 0;
  int          req_cyc = 0;
  int          rw_both = 0;
  int          unstable = 0;
  int          log_n = 0;
  logic [15:0] log_addr [0:63];
  logic [7:0]  log_dat  [0:63];
  logic        log_wr   [0:63];
  int          log_cyc  [0:63];
  logic [15:0] p_addr;
  logic [7:0]  p_wdat;
  logic        p_wr;

  initial begin
    resp_ack  = 1'b0;
    mem_rdata = 8'h00;
  end

  always @(negedge clk) begin
    if (rst) begin
      wcnt     = 0;
      resp_ack = 1'b0;
    end else if (mem_wr || mem_rd) begin
      req_cyc++;
      if (mem_wr && mem_rd) rw_both++;
      if (wcnt > 0 && (mem_addr !== p_addr || mem_wdata !== p_wdat || mem_wr !== p_wr)) unstable++;
      p_addr = mem_addr;
      p_wdat = mem_wdata;
      p_wr   = mem_wr;
      if (wcnt >= wait_n) begin
        resp_ack = 1'b1;
        if (mem_wr) mem[mem_addr] = mem_wdata;
        else mem_rdata = mem[mem_addr];
        if (log_n < 64) begin
          log_addr[log_n] = mem_addr;
          log_dat[log_n]  = mem_wr ? mem_wdata : mem[mem_addr];
          log_wr[log_n]   = mem_wr;
          log_cyc[log_n]  = wcnt + 1;
          log_n++;
        end
        wcnt = 0;
      end else begin
        resp_ack = 1'b0;
        wcnt++;
      end
    end else begin
      resp_ack = 1'b0;
      wcnt     = 0;
    end
  end

  task automatic load_sp(input logic [15:0] v);
    @(negedge clk);
    sp_load = 1'b1;
    iSP     = v;
    @(negedge clk);
    sp_load = 1'b0;
  endtask

  // Returns at the negedge where done is seen; lat counts cycles after the start-sampling edge.
  task automatic run_op(input logic op, input logic [15:0] d, input int wn,
                        output int lat, output logic b1);
    @(negedge clk);
    wait_n = wn;
    stk_op = op;
    iData  = d;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    b1    = busy;
    lat   = 1;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({oSP, oData, mem_addr} !== 48'h0) begin
      errors++;
      $display("FAIL reset_regs: got sp=%h data=%h addr=%h want 0", oSP, oData, mem_addr);
    end
    checks++;
    if ({mem_wdata, mem_wr, mem_rd, busy, done} !== 12'h0) begin
      errors++;
      $display("FAIL reset_ctl: got wd=%h wr=%b rd=%b busy=%b done=%b want 0",
               mem_wdata, mem_wr, mem_rd, busy, done);
    end
    rst = 1'b0;
  endtask

  task automatic test_push_basic();
    int lat; logic b1; int base;
    load_sp(16'h2000);
    checks++;
    if (oSP !== 16'h2000) begin errors++; $display("FAIL sp_load: got %h want 2000", oSP); end
    base = log_n;
    run_op(1'b0, 16'hBEEF, 0, lat, b1);
    checks++;
    if (lat !== 3 || b1 !== 1'b1) begin errors++; $display("FAIL push_latency: got lat=%0d busy=%b want 3/1", lat, b1); end
    checks++;
    if (log_n - base !== 2 || log_addr[base] !== 16'h1FFF || log_dat[base] !== 8'hBE || log_wr[base] !== 1'b1) begin
      errors++;
      $display("FAIL push_byte_hi: got n=%0d %h@%h wr=%b want 2 BE@1FFF 1", log_n - base, log_dat[base], log_addr[base], log_wr[base]);
    end
    checks++;
    if (log_addr[base+1] !== 16'h1FFE || log_dat[base+1] !== 8'hEF || log_wr[base+1] !== 1'b1) begin
      errors++;
      $display("FAIL push_byte_lo: got %h@%h wr=%b want EF@1FFE 1", log_dat[base+1], log_addr[base+1], log_wr[base+1]);
    end
    checks++;
    if (oSP !== 16'h1FFE || oData !== 16'h0000) begin
      errors++;
      $display("FAIL push_sp: got sp=%h data=%h want 1FFE 0000", oSP, oData);
    end
  endtask

  task automatic test_pop_basic();
    int lat; logic b1; int base;
    base = log_n;
    run_op(1'b1, 16'h0000, 0, lat, b1);
    checks++;
    if (lat !== 3 || b1 !== 1'b1) begin errors++; $display("FAIL pop_latency: got lat=%0d busy=%b want 3/1", lat, b1); end
    checks++;
    if (log_n - base !== 2 || log_addr[base] !== 16'h1FFE || log_addr[base+1] !== 16'h1FFF || log_wr[base] !== 1'b0 || log_wr[base+1] !== 1'b0) begin
      errors++;
      $display("FAIL pop_addrs: got n=%0d %h,%h want 2 1FFE,1FFF reads", log_n - base, log_addr[base], log_addr[base+1]);
    end
    checks++;
    if (oData !== 16'hBEEF || oSP !== 16'h2000) begin
      errors++;
      $display("FAIL pop_result: got data=%h sp=%h want BEEF 2000", oData, oSP);
    end
  endtask

  task automatic test_wait_states();
    int lat; logic b1; int base; int u0;
    load_sp(16'h3000);
    base = log_n;
    u0   = unstable;
    run_op(1'b0, 16'hA55A, 3, lat, b1);
    wait_n = 0;
    checks++;
    if (lat !== 9) begin errors++; $display("FAIL wait_latency: got %0d want 9", lat); end
    checks++;
    if (log_n - base !== 2 || log_cyc[base] !== 4 || log_cyc[base+1] !== 4) begin
      errors++;
      $display("FAIL wait_hold: got n=%0d cyc=%0d,%0d want 2 4,4", log_n - base, log_cyc[base], log_cyc[base+1]);
    end
    checks++;
    if (unstable - u0 !== 0 || log_addr[base] !== 16'h2FFF || log_dat[base+1] !== 8'h5A) begin
      errors++;
      $display("FAIL wait_stable: got unstable=%0d a=%h d=%h want 0 2FFF 5A", unstable - u0, log_addr[base], log_dat[base+1]);
    end
    checks++;
    if (oSP !== 16'h2FFE) begin errors++; $display("FAIL wait_sp: got %h want 2FFE", oSP); end
  endtask

  task automatic test_wrap();
    int lat; logic b1; int base;
    load_sp(16'h0000);
    base = log_n;
    run_op(1'b0, 16'h1234, 0, lat, b1);
    checks++;
    if (log_addr[base] !== 16'hFFFF || log_dat[base] !== 8'h12 || log_addr[base+1] !== 16'hFFFE || log_dat[base+1] !== 8'h34 || oSP !== 16'hFFFE) begin
      errors++;
      $display("FAIL wrap_push0: got %h@%h %h@%h sp=%h want 12@FFFF 34@FFFE FFFE",
               log_dat[base], log_addr[base], log_dat[base+1], log_addr[base+1], oSP);
    end
    load_sp(16'h0001);
    base = log_n;
    run_op(1'b0, 16'h5678, 0, lat, b1);
    checks++;
    if (log_addr[base] !== 16'h0000 || log_addr[base+1] !== 16'hFFFF || oSP !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_push1: got %h,%h sp=%h want 0000,FFFF FFFF", log_addr[base], log_addr[base+1], oSP);
    end
    base = log_n;
    run_op(1'b1, 16'h0000, 0, lat, b1);
    checks++;
    if (log_addr[base] !== 16'hFFFF || log_addr[base+1] !== 16'h0000 || oSP !== 16'h0001 || oData !== 16'h5678) begin
      errors++;
      $display("FAIL wrap_pop: got %h,%h sp=%h data=%h want FFFF,0000 0001 5678",
               log_addr[base], log_addr[base+1], oSP, oData);
    end
  endtask

  task automatic test_conflict();
    int r0;
    r0 = req_cyc;
    @(negedge clk);
    start   = 1'b1;
    stk_op  = 1'b0;
    sp_load = 1'b1;
    iSP     = 16'h4000;
    @(negedge clk);
    start   = 1'b0;
    sp_load = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (oSP !== 16'h4000 || req_cyc - r0 !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_wins: got sp=%h reqs=%0d busy=%b want 4000 0 0", oSP, req_cyc - r0, busy);
    end
  endtask

  task automatic test_back_to_back();
    int base; int n;
    base = log_n;
    @(negedge clk);
    stk_op = 1'b0;
    iData  = 16'hC0DE;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (log_n - base !== 2 || oSP !== 16'h3FFE || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start: got n=%0d sp=%h busy=%b want 2 3FFE 0", log_n - base, oSP, busy);
    end
  endtask

  task automatic test_stray_ack();
    int r0;
    r0 = req_cyc;
    @(negedge clk);
    stray_ack = 1'b1;
    repeat (3) @(negedge clk);
    stray_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (oSP !== 16'h3FFE || req_cyc - r0 !== 0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack: got sp=%h reqs=%0d done=%b busy=%b want 3FFE 0 0 0", oSP, req_cyc - r0, done, busy);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    load_sp(16'h3000);
    @(negedge clk);
    wait_n = 5;
    stk_op = 1'b0;
    iData  = 16'h7711;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (mem_wr !== 1'b1 || mem_addr !== 16'h2FFE || mem_wdata !== 8'h11) begin
      errors++;
      $display("FAIL pre_abort: got wr=%b addr=%h wd=%h want 1 2FFE 11", mem_wr, mem_addr, mem_wdata);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({oSP, oData, mem_addr, mem_wdata, mem_wr, mem_rd, busy, done} !== 60'h0) begin
      errors++;
      $display("FAIL async_reset: got sp=%h data=%h addr=%h wd=%h wr=%b rd=%b busy=%b done=%b want 0",
               oSP, oData, mem_addr, mem_wdata, mem_wr, mem_rd, busy, done);
    end
    @(negedge clk);
    rst    = 1'b0;
    wait_n = 0;
    r0     = req_cyc;
    repeat (6) @(negedge clk);
    checks++;
    if (oSP !== 16'h0000 || req_cyc - r0 !== 0 || done !== 1'b0) begin
      errors++;
      $display("FAIL post_abort: got sp=%h reqs=%0d done=%b want 0000 0 0", oSP, req_cyc - r0, done);
    end
    checks++;
    if (rw_both !== 0) begin errors++; $display("FAIL rd_wr_excl: got %0d overlaps want 0", rw_both); end
  endtask

  initial begin
    start     = 1'b0;
    stk_op    = 1'b0;
    iData     = 16'h0;
    sp_load   = 1'b0;
    iSP       = 16'h0;
    stray_ack = 1'b0;
    rst       = 1'b1;
    test_reset();
    test_push_basic();
    test_pop_basic();
    test_wait_states();
    test_wrap();
    test_conflict();
    test_back_to_back();
    test_stray_ack();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Sequencer for 8085 PUSH/POP stack transfers.
- Owns the 16-bit stack pointer and splits each 16-bit word into two byte accesses on the memory request/acknowledge interface.
- PUSH pre-decrements SP by 2. POP post-increments SP by 2.
- Sits between the control unit (start/done) and the bus interface unit (mem_* handshake).

Parameters:
- DATASIZE, 8: memory data width; word width is 2*DATASIZE.
- ADDRSIZE, 16: address and SP width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin stack operation; sampled in IDLE only.
- stk_op  input  1  1 = POP (SP increments), 0 = PUSH (SP decrements).
- iData  input  2*DATASIZE  word to push; captured at accepted start.
- oData  output  2*DATASIZE  last popped word.
- sp_load  input  1  load SP from iSP; honoured in IDLE only.
- iSP  input  ADDRSIZE  SP load value.
- oSP  output  ADDRSIZE  current stack pointer.
- busy  output  1  high from the cycle after accepted start through the final acknowledge.
- done  output  1  one-cycle pulse after the second byte is acknowledged.
- mem_addr  output  ADDRSIZE  byte address of the current access.
- mem_wdata  output  DATASIZE  write byte.
- mem_rdata  input  DATASIZE  read byte; valid when mem_ack=1.
- mem_wr  output  1  write request, level.
- mem_rd  output  1  read request, level.
- mem_ack  input  1  access complete this cycle.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE; oSP=0; oData=0; mem_addr=0; mem_wdata=0; mem_wr=mem_rd=busy=done=0. An aborted operation leaves no SP change and issues no further strobes.
- All outputs are registered.
- States:
  - IDLE: start=1 and sp_load=0 → capture iData and stk_op; go to PUSH_HI or POP_LO.
  - PUSH_HI: mem_wr=1, addr=SP-1, wdata=iData[15:8]. On ack → PUSH_LO.
  - PUSH_LO: mem_wr=1, addr=SP-2, wdata=iData[7:0]. On ack → FIN; SP ← SP-2.
  - POP_LO: mem_rd=1, addr=SP. On ack → latch rdata into low byte → POP_HI.
  - POP_HI: mem_rd=1, addr=SP+1. On ack → latch high byte → FIN; SP ← SP+2; oData updates with the full word.
  - FIN: done=1, busy=0, no strobes → IDLE.
- Handshake:
  - Request level is held, with address and data stable, until sampled with mem_ack=1.
  - mem_ack may arrive in the first request cycle, giving zero wait states.
  - The next byte's request is asserted in the cycle after the ack; the request stays high continuously across the two accesses, with addr/data switching.
  - mem_ack outside a request is ignored.
  - mem_rd and mem_wr are never high together.
- Latency with zero wait states: start sampled at edge N → first request in cycle N+1, second in N+2, done in N+3. Each wait cycle adds 1.
- SP arithmetic is modulo 2^ADDRSIZE. SP changes only once, at the final ack (atomic); oSP is stable during the operation.
- Wrap examples:
  - PUSH at SP=0x0000 writes 0xFFFF then 0xFFFE; SP=0xFFFE.
  - PUSH at SP=0x0001 writes 0x0000 then 0xFFFF; SP=0xFFFF.
  - POP at SP=0xFFFF reads 0xFFFF then 0x0000; SP=0x0001.
- sp_load in IDLE: oSP ← iSP next edge.
- sp_load and start in the same IDLE cycle: sp_load wins and start is dropped. The control unit must re-issue start.
- start or sp_load while not IDLE (including FIN): ignored.
- Back-to-back operations: start may be asserted during FIN. It is ignored and must be re-sampled in IDLE, so the minimum op-to-op spacing is 4 cycles.
- oData holds its value through PUSH operations; it changes only at POP completion.

Test Plan:
- Reset, then sp_load with iSP=0x2000; PUSH iData=0xBEEF, ack immediate → writes 0xBE@0x1FFF then 0xEF@0x1FFE; done at cycle N+3; oSP=0x1FFE.
- Following POP, ack immediate, rdata supplied from the prior writes → reads 0x1FFE then 0x1FFF; oData=0xBEEF; oSP=0x2000.
- PUSH with 3 wait cycles per byte → strobe, address and wdata held stable for 4 cycles per byte; done at N+9; no double write.
- Wrap: SP=0x0000 PUSH 0x1234 → 0x12@0xFFFF, 0x34@0xFFFE, SP=0xFFFE. SP=0xFFFF POP → addresses 0xFFFF, 0x0000; SP=0x0001.
- start+sp_load together (iSP=0x4000) → SP=0x4000, no strobes. start while busy → no second operation. Stray mem_ack in IDLE → no effect.
- rst asserted during PUSH_LO wait (SP was 0x3000) → all outputs 0 immediately, asynchronously; after release SP=0x0000 and no strobes until a new start.
